// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter that owns the single register-file write
//               port. Optional macro REG_ARB_ZERO_GUARD_EN suppresses wr_en on
//               grants whose address is register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data
);

    localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ - 1);

    logic [c_PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]    r_gnt;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_hi_found;
    logic [c_PTR_W-1:0]    w_hi_idx;
    logic [ADDR_WIDTH-1:0] w_hi_addr;
    logic [DATA_WIDTH-1:0] w_hi_data;
    logic                  w_lo_found;
    logic [c_PTR_W-1:0]    w_lo_idx;
    logic [ADDR_WIDTH-1:0] w_lo_addr;
    logic [DATA_WIDTH-1:0] w_lo_data;
    logic                  w_found;
    logic [c_PTR_W-1:0]    w_win;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [c_PTR_W-1:0]    w_next_ptr;
    logic                  w_en_sel;

    // The requester granted this cycle still shows req at the next edge;
    // masking it out prevents the same write being issued twice.
    assign w_elig = req & ~r_gnt;

    // Two lowest-index searches: one restricted to indices >= ptr, one over
    // all indices. The restricted hit wins; otherwise the search has wrapped.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_hi_addr  = '0;
        w_hi_data  = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        w_lo_addr  = '0;
        w_lo_data  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = c_PTR_W'(i);
                w_lo_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_lo_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (c_PTR_W'(i) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_PTR_W'(i);
                    w_hi_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    w_hi_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign w_found    = w_hi_found | w_lo_found;
    assign w_win      = w_hi_found ? w_hi_idx  : w_lo_idx;
    assign w_sel_addr = w_hi_found ? w_hi_addr : w_lo_addr;
    assign w_sel_data = w_hi_found ? w_hi_data : w_lo_data;
    assign w_next_ptr = (w_win == c_LAST) ? '0 : w_win + 1'b1;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_onehot
            assign w_onehot[g] = (w_win == c_PTR_W'(g));
        end
    endgenerate

`ifdef REG_ARB_ZERO_GUARD_EN
    // Register 0 is hardwired to zero: grant and advance, but never write it.
    assign w_en_sel = (w_sel_addr != '0);
`else
    assign w_en_sel = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_found) begin
            r_ptr     <= w_next_ptr;
            r_gnt     <= w_onehot;
            r_wr_en   <= w_en_sel;
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
        end else begin
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
        end
    end

    assign gnt     = r_gnt;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;

    int checks;
    int failures;

    // Behavioural model state
    logic [NR-1:0] m_gnt;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_ptr;

    reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REG_ARB_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    task automatic model_reset();
        m_gnt  = '0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ptr  = 0;
    endtask

    // Applies the arbitration rule to the inputs present just before an edge.
    task automatic model_step();
        bit found;
        int w;
        found = 1'b0;
        w     = 0;
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (!found && req[idx] && !m_gnt[idx]) begin
                    found = 1'b1;
                    w     = idx;
                end
            end
            if (found) begin
                m_gnt  = NR'(1 << w);
                m_addr = req_addr[w*AW +: AW];
                m_data = req_data[w*DW +: DW];
                m_en   = GUARD ? (m_addr != 0) : 1'b1;
                m_ptr  = (w + 1) % NR;
            end else begin
                m_gnt = '0;
                m_en  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_io(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NR; i++) set_io(i, AW'(i + 8), 32'hA000_0000 + DW'(i));
        tick();
        tick();
        checks++;
        if ({gnt, wr_en, wr_addr, wr_data} !== {4'b0000, 1'b0, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_hold: gnt=%b en=%b addr=%0d data=%h, want 0000 0 0 0", gnt, wr_en, wr_addr, wr_data);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt, wr_en, wr_addr, wr_data} !== {4'b0001, 1'b1, 5'd8, 32'hA000_0000}) begin
            failures++;
            $display("FAIL reset_first_grant: gnt=%b en=%b addr=%0d data=%h, want 0001 1 8 a0000000", gnt, wr_en, wr_addr, wr_data);
        end
        req = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        set_io(1, 5'd5, 32'hDEADBEEF);
        tick();
        checks++;
        if ({gnt, wr_en, wr_addr, wr_data} !== {4'b0010, 1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_edge1: gnt=%b en=%b addr=%0d data=%h, want 0010 1 5 deadbeef", gnt, wr_en, wr_addr, wr_data);
        end
        tick();
        checks++;
        if ({gnt, wr_en, wr_addr, wr_data} !== {4'b0000, 1'b0, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_edge2: gnt=%b en=%b addr=%0d data=%h, want 0000 0 5 deadbeef", gnt, wr_en, wr_addr, wr_data);
        end
        tick();
        checks++;
        if ({gnt, wr_en} !== {4'b0010, 1'b1}) begin
            failures++;
            $display("FAIL single_edge3: gnt=%b en=%b, want 0010 1", gnt, wr_en);
        end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) set_io(i, AW'(20 + i), 32'hC0DE_0000 + DW'(i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [NR-1:0] eg;
            eg = NR'(1 << (k % NR));
            tick();
            checks++;
            if ({gnt, wr_en, wr_addr, wr_data} !== {eg, 1'b1, AW'(20 + k % NR), 32'hC0DE_0000 + DW'(k % NR)}) begin
                failures++;
                $display("FAIL round_robin[%0d]: gnt=%b en=%b addr=%0d data=%h, want gnt=%b en=1", k, gnt, wr_en, wr_addr, wr_data, eg);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        set_io(0, 5'd1, 32'h0000_0001);
        set_io(2, 5'd3, 32'h0000_0003);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_setup: gnt=%b, want 0100", gnt);
        end
        req = 4'b0101;
        tick();
        checks++;
        if ({gnt, wr_addr} !== {4'b0001, 5'd1}) begin
            failures++;
            $display("FAIL wrap_to_0: gnt=%b addr=%0d, want 0001 1", gnt, wr_addr);
        end
        tick();
        checks++;
        if ({gnt, wr_addr} !== {4'b0100, 5'd3}) begin
            failures++;
            $display("FAIL wrap_then_2: gnt=%b addr=%0d, want 0100 3", gnt, wr_addr);
        end
        req = '0;
        tick();
    endtask

    task automatic test_zero_guard();
        do_reset();
        set_io(0, 5'd0, 32'h12345678);
        req = 4'b0001;
        tick();
        checks++;
        if ({gnt, wr_en, wr_data} !== {4'b0001, ~GUARD, 32'h12345678}) begin
            failures++;
            $display("FAIL zero_guard: gnt=%b en=%b data=%h, want 0001 %b 12345678", gnt, wr_en, wr_data, ~GUARD);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_io(2, 5'd9, 32'h0BAD_F00D);
        req = 4'b0100;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL mid_setup: gnt=%b, want 0100", gnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, wr_en, wr_addr, wr_data} !== {4'b0000, 1'b0, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL mid_async_reset: gnt=%b en=%b addr=%0d data=%h, want all 0", gnt, wr_en, wr_addr, wr_data);
        end
        #2;
        rst = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({gnt, wr_en, wr_addr, wr_data} !== {4'b0100, 1'b1, 5'd9, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL mid_regrant: gnt=%b en=%b addr=%0d data=%h, want 0100 1 9 0badf00d", gnt, wr_en, wr_addr, wr_data);
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                checks++;
                if ({gnt, wr_en, wr_addr, wr_data} !== {m_gnt, m_en, m_addr, m_data}) begin
                    failures++;
                    $display("FAIL random_reset[%0d]: gnt=%b en=%b addr=%0d data=%h, want all 0", c, gnt, wr_en, wr_addr, wr_data);
                end
                #1;
                rst = 1'b1;
            end
            req = NR'($urandom);
            for (int i = 0; i < NR; i++)
                set_io(i, ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom), DW'($urandom));
            tick();
            checks++;
            if ({gnt, wr_en, wr_addr, wr_data} !== {m_gnt, m_en, m_addr, m_data}) begin
                failures++;
                $display("FAIL random[%0d]: gnt=%b en=%b addr=%0d data=%h, want gnt=%b en=%b addr=%0d data=%h",
                         c, gnt, wr_en, wr_addr, wr_data, m_gnt, m_en, m_addr, m_data);
            end
        end
        req = '0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_zero_guard();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
